iq_sample_fifo: RTL and testbench

Upstream neighbour of the Packetizer: takes I/Q samples from the DSP chain and packs each pair into a 32-bit word. Buffers words in a single-clock first-word-fall-through (FWFT) FIFO. Presents the Packetizer's read-side interface (rd_en / rd_data / rd_dr). rd_dr asserts only when a full payload burst is buffered, so the Packetizer never starts a frame it cannot finish.

---
 rtl/sdr_pkg.sv | 19 +
 rtl/sync_fifo_fwft.sv | 75 +++++++
 rtl/iq_sample_fifo.sv | 100 ++++++++++
 tb/tb_iq_sample_fifo.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sdr_pkg                                                              |
// | Shared sample/word widths and the I/Q packing helper.                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sdr_pkg;

  localparam int SAMPLE_W  = 16;
  localparam int WORD_W    = 32;
  localparam int OVF_CNT_W = 16;

  function automatic logic [WORD_W-1:0] iq_pack(input logic [SAMPLE_W-1:0] i,
                                                input logic [SAMPLE_W-1:0] q);
    return {i, q};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_fwft                                                       |
// | Single-clock first-word-fall-through FIFO, level-based full/empty.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo_fwft #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   level_nxt
);

  localparam int                  C_DEPTH_N   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_LVL_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem [C_DEPTH_N];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_empty;
  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_level_nxt;

  assign full  = (r_level == C_DEPTH);
  assign w_pop = rd_en && !r_empty;
  // A full FIFO still takes a write when the same edge frees a slot.
  assign w_push = wr_en && (!full || w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop)
      w_level_nxt = r_level + C_LVL_ONE;
    else if (w_pop && !w_push)
      w_level_nxt = r_level - C_LVL_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem[r_wr_ptr] <= wr_data;
  end

  // Stale array contents are masked so an empty FIFO always reads zero.
  assign rd_data   = r_empty ? '0 : mem[r_rd_ptr];
  assign empty     = r_empty;
  assign level     = r_level;
  assign level_nxt = w_level_nxt;

endmodule
`default_nettype wire

// File: rtl/iq_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | iq_sample_fifo                                                       |
// | Packs I/Q pairs, buffers them and flags a ready payload burst.       |
// | Optional macro TEST_PATTERN_EN adds test_en and a counter pattern.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module iq_sample_fifo
  import sdr_pkg::*;
#(
  parameter int DEPTH_LOG2  = 8,
  parameter int BURST_WORDS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [15:0]           in_i,
  input  logic [15:0]           in_q,
`ifdef TEST_PATTERN_EN
  input  logic                  test_en,
`endif
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic                  rd_dr,
  output logic                  rd_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [15:0]           overflow_cnt,
  output logic                  underflow
);

  localparam logic [DEPTH_LOG2:0]  C_BURST   = (DEPTH_LOG2+1)'(BURST_WORDS);
  localparam logic [OVF_CNT_W-1:0] C_OVF_ONE = {{(OVF_CNT_W-1){1'b0}}, 1'b1};

  logic [WORD_W-1:0]    w_wr_data;
  logic                 w_full;
  logic [DEPTH_LOG2:0]  w_level_nxt;
  logic                 w_drop;
  logic                 r_dr;
  logic                 r_overflow;
  logic [OVF_CNT_W-1:0] r_ovf_cnt;
  logic                 r_underflow;

`ifdef TEST_PATTERN_EN
  logic [WORD_W-1:0] r_tp_cnt;

  // Counter advances on every strobe, dropped or not, so gaps reveal drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tp_cnt <= '0;
    else if (in_valid)
      r_tp_cnt <= r_tp_cnt + 32'd1;
  end

  assign w_wr_data = test_en ? r_tp_cnt : iq_pack(in_i, in_q);
`else
  assign w_wr_data = iq_pack(in_i, in_q);
`endif

  sync_fifo_fwft #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (in_valid),
    .wr_data   (w_wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (rd_empty),
    .full      (w_full),
    .level     (level),
    .level_nxt (w_level_nxt)
  );

  assign w_drop = in_valid && w_full && !(rd_en && !rd_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dr        <= 1'b0;
      r_overflow  <= 1'b0;
      r_ovf_cnt   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_dr <= (w_level_nxt >= C_BURST);
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + C_OVF_ONE;
      end
      if (rd_en && rd_empty) r_underflow <= 1'b1;
    end
  end

  assign rd_dr        = r_dr;
  assign overflow     = r_overflow;
  assign overflow_cnt = r_ovf_cnt;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_iq_sample_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_iq_sample_fifo                                                    |
// | Directed self-checking bench for iq_sample_fifo (default params).    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_iq_sample_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_i = '0;
  logic [15:0] in_q = '0;
  logic        rd_en = 1'b0;
`ifdef TEST_PATTERN_EN
  logic        test_en = 1'b0;
`endif
  logic [31:0] rd_data;
  logic        rd_dr;
  logic        rd_empty;
  logic [8:0]  level;
  logic        overflow;
  logic [15:0] overflow_cnt;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  iq_sample_fifo #(.DEPTH_LOG2(8), .BURST_WORDS(128)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_i         (in_i),
    .in_q         (in_q),
`ifdef TEST_PATTERN_EN
    .test_en      (test_en),
`endif
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_dr        (rd_dr),
    .rd_empty     (rd_empty),
    .level        (level),
    .overflow     (overflow),
    .overflow_cnt (overflow_cnt),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int k);
    logic [15:0] a;
    a = 16'(k);
    return {a, a ^ 16'h5A5A};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push_k(input int k);
    logic [31:0] w;
    w = exp_word(k);
    in_i = w[31:16];
    in_q = w[15:0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (level !== 9'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (rd_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", rd_empty); end
    checks++; if (rd_dr !== 1'b0) begin errors++; $display("FAIL reset_dr got %b exp 0", rd_dr); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overflow, underflow}); end
    checks++; if (overflow_cnt !== 16'd0) begin errors++; $display("FAIL reset_ovfcnt got %0d exp 0", overflow_cnt); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h exp 0", rd_data); end
  endtask

  task automatic test_single();
    do_reset();
    in_i = 16'h8c63; in_q = 16'h436c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (rd_empty !== 1'b0) begin errors++; $display("FAIL single_empty got %b exp 0", rd_empty); end
    checks++; if (rd_data !== 32'h8c63436c) begin errors++; $display("FAIL single_data got %h exp 8c63436c", rd_data); end
    checks++; if (level !== 9'd1) begin errors++; $display("FAIL single_level got %0d exp 1", level); end
    checks++; if (rd_dr !== 1'b0) begin errors++; $display("FAIL single_dr got %b exp 0", rd_dr); end
  endtask

  task automatic test_threshold();
    do_reset();
    for (int k = 0; k < 127; k++) push_k(k);
    checks++; if (rd_dr !== 1'b0) begin errors++; $display("FAIL thr_dr_127 got %b exp 0", rd_dr); end
    push_k(127);
    checks++; if (rd_dr !== 1'b1) begin errors++; $display("FAIL thr_dr_128 got %b exp 1", rd_dr); end
    checks++; if (level !== 9'd128) begin errors++; $display("FAIL thr_level got %0d exp 128", level); end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (rd_dr !== 1'b0) begin errors++; $display("FAIL thr_dr_pop got %b exp 0", rd_dr); end
    checks++; if (level !== 9'd127) begin errors++; $display("FAIL thr_level_pop got %0d exp 127", level); end
    checks++; if (rd_data !== exp_word(1)) begin errors++; $display("FAIL thr_head got %h exp %h", rd_data, exp_word(1)); end
  endtask

  task automatic test_overflow();
    int bad;
    do_reset();
    for (int k = 0; k < 256; k++) push_k(k);
    for (int k = 0; k < 5; k++) push_k(1000 + k);
    checks++; if (level !== 9'd256) begin errors++; $display("FAIL ovf_level got %0d exp 256", level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++; if (overflow_cnt !== 16'd5) begin errors++; $display("FAIL ovf_cnt got %0d exp 5", overflow_cnt); end
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (rd_data !== exp_word(k)) begin
        errors++;
        if (bad < 4) $display("FAIL ovf_drain[%0d] got %h exp %h", k, rd_data, exp_word(k));
        bad++;
      end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    checks++; if (rd_empty !== 1'b1 || level !== 9'd0) begin errors++; $display("FAIL ovf_drained got empty=%b level=%0d exp 1/0", rd_empty, level); end
    checks++; if (overflow_cnt !== 16'd5) begin errors++; $display("FAIL ovf_cnt_sticky got %0d exp 5", overflow_cnt); end
  endtask

  task automatic test_full_push_pop();
    int bad;
    do_reset();
    for (int k = 0; k < 256; k++) push_k(k);
    in_i = 16'hAAAA; in_q = 16'h5555; in_valid = 1'b1; rd_en = 1'b1;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    checks++; if (level !== 9'd256) begin errors++; $display("FAIL fpp_level got %0d exp 256", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b exp 0", overflow); end
    bad = 0;
    for (int k = 1; k < 256; k++) begin
      checks++;
      if (rd_data !== exp_word(k)) begin
        errors++;
        if (bad < 4) $display("FAIL fpp_drain[%0d] got %h exp %h", k, rd_data, exp_word(k));
        bad++;
      end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    checks++; if (rd_data !== 32'hAAAA5555) begin errors++; $display("FAIL fpp_last got %h exp aaaa5555", rd_data); end
  endtask

  task automatic test_underflow_and_async_reset();
    do_reset();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_flag got %b exp 1", underflow); end
    checks++; if (level !== 9'd0 || rd_empty !== 1'b1) begin errors++; $display("FAIL uf_level got %0d/%b exp 0/1", level, rd_empty); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL uf_data got %h exp 0", rd_data); end
    in_i = 16'h1234; in_q = 16'h5678; in_valid = 1'b1; rd_en = 1'b1;
    tick();
    in_valid = 1'b0; rd_en = 1'b0;
    checks++; if (level !== 9'd1 || rd_data !== 32'h12345678) begin errors++; $display("FAIL uf_pushpop got %0d/%h exp 1/12345678", level, rd_data); end
    do_reset();
    for (int k = 0; k < 100; k++) push_k(k);
    checks++; if (level !== 9'd100) begin errors++; $display("FAIL ar_pre_level got %0d exp 100", level); end
    rst = 1'b1;
    #1;
    checks++; if (level !== 9'd0 || rd_empty !== 1'b1 || rd_dr !== 1'b0) begin errors++; $display("FAIL ar_async got level=%0d empty=%b dr=%b exp 0/1/0", level, rd_empty, rd_dr); end
    checks++; if (rd_data !== 32'd0 || underflow !== 1'b0) begin errors++; $display("FAIL ar_async_data got %h uf=%b exp 0/0", rd_data, underflow); end
    tick();
    rst = 1'b0;
    tick();
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    int bad;
    do_reset();
    test_en = 1'b1; in_valid = 1'b1; rd_en = 1'b1;
    tick();
    bad = 0;
    for (int n = 0; n < 300; n++) begin
      checks++;
      if (rd_data !== 32'(n) || level > 9'd1) begin
        errors++;
        if (bad < 4) $display("FAIL tp[%0d] got %h level=%0d exp %h level<=1", n, rd_data, level, 32'(n));
        bad++;
      end
      tick();
    end
    in_valid = 1'b0; rd_en = 1'b0; test_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_threshold();
    test_overflow();
    test_full_push_pop();
    test_underflow_and_async_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
